// File: rtl/ps2_kbd_display_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and status display.
package ps2_kbd_display_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {IDLE, BREAK} dec_state_t;

    // Active-low segment patterns, dp off; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/ps2_kbd_display_if.sv
// Board-side pins of the keyboard display block: PS/2 inputs and status outputs.
interface ps2_kbd_display_if #(parameter int NUM_DIGITS = 8);
    logic                    ps2_clk;
    logic                    ps2_data;
    logic [8*NUM_DIGITS-1:0] seg;
    logic [7:0]              scan_code;
    logic                    key_down;
    logic [7:0]              press_cnt;
    logic [7:0]              frame_err;
    logic                    overflow;

    modport master (output ps2_clk, ps2_data,
                    input  seg, scan_code, key_down, press_cnt, frame_err, overflow);
    modport slave  (input  ps2_clk, ps2_data,
                    output seg, scan_code, key_down, press_cnt, frame_err, overflow);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge sampling, 11-bit frame check,
// inter-bit timeout and a saturating rejected-frame counter.
module ps2_frame_rx #(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_prev;
    logic [9:0]             r_shift;
    logic [3:0]             r_bitcnt;
    logic [TW-1:0]          r_tcnt;

    logic        w_fall, w_bit, w_last, w_good, w_timeout, w_reject;
    logic [10:0] w_frame;

    assign w_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit     = r_dat_sync[SYNC_STAGES-1];
    // [0]=start, [8:1]=data, [9]=odd parity, [10]=stop
    assign w_frame   = {w_bit, r_shift};
    assign w_last    = w_fall && (r_bitcnt == 4'd10);
    assign w_good    = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
    assign w_timeout = !w_fall && (r_bitcnt != 4'd0) && (r_tcnt == TW'(TIMEOUT_CYC - 1));
    assign w_reject  = (w_last && !w_good) || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_tcnt     <= '0;
            o_byte     <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
            o_valid    <= w_last && w_good;
            o_err      <= w_reject;
            if (w_last && w_good)
                o_byte <= w_frame[8:1];
            if (w_reject && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 8'd1;

            if (w_fall) begin
                r_tcnt <= '0;
                if (w_last) begin
                    r_bitcnt <= '0;
                end else begin
                    r_shift  <= w_frame[10:1];
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                if (w_timeout) begin
                    r_bitcnt <= '0;
                    r_tcnt   <= '0;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ps2_kbd_display.sv
// PS/2 keyboard top: frame receiver, scan-code FIFO, make/break decoder and
// seven-segment status display.
module ps2_kbd_display
    import ps2_kbd_display_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 5000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    ps2_kbd_display_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  w_rx_byte, w_rx_err_cnt, w_head;
    logic        w_rx_valid, w_rx_err, w_pop, w_push, w_full;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_count;
    logic        r_overflow, r_key_down;
    logic [7:0]  r_scan, r_press;
    dec_state_t  r_state;
    logic [8*NUM_DIGITS-1:0] w_seg;

    ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .i_ps2_clk (bus.ps2_clk),
        .i_ps2_data(bus.ps2_data),
        .o_byte    (w_rx_byte),
        .o_valid   (w_rx_valid),
        .o_err     (w_rx_err),
        .o_err_cnt (w_rx_err_cnt)
    );

    assign w_pop  = (r_count != '0);
    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_push = w_rx_valid && (!w_full || w_pop);
    assign w_head = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= w_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_rx_valid && !w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_scan     <= '0;
            r_key_down <= 1'b0;
            r_press    <= '0;
        end else if (w_pop) begin
            case (r_state)
                IDLE: begin
                    if (w_head == PS2_BREAK) begin
                        r_state <= BREAK;
                    end else if (w_head != PS2_EXT && (!r_key_down || w_head != r_scan)) begin
                        r_scan     <= w_head;
                        r_key_down <= 1'b1;
                        r_press    <= r_press + 8'd1;
                    end
                end
                BREAK: begin
                    if (w_head != PS2_EXT) begin
                        r_state <= IDLE;
                        if (w_head == r_scan) begin
                            r_key_down <= 1'b0;
                            r_scan     <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Display is held blank while reset is asserted so every digit reads off.
    always_comb begin
        w_seg = {NUM_DIGITS{SEG_BLANK}};
        if (!rst) begin
            if (r_key_down) begin
                w_seg[7:0]  = HEX_SEG[r_scan[3:0]];
                w_seg[15:8] = HEX_SEG[r_scan[7:4]];
            end
            w_seg[23:16] = HEX_SEG[r_press[3:0]];
            w_seg[31:24] = HEX_SEG[r_press[7:4]];
        end
    end

    assign bus.seg       = w_seg;
    assign bus.scan_code = r_scan;
    assign bus.key_down  = r_key_down;
    assign bus.press_cnt = r_press;
    assign bus.frame_err = w_rx_err_cnt;
    assign bus.overflow  = r_overflow;
endmodule

// File: doc/ps2_kbd_display.md
Name: ps2_kbd_display

Overview:
PS/2 keyboard receiver with a buffered scan-code path, make/break tracking and a seven-segment status display for the board top level. It sits between the board's ps2_clk/ps2_data pins and the seg/ledr outputs. It replaces tied-off display outputs with live key state, and is parametrised in FIFO depth, synchroniser length, frame timeout and digit count.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries (power of two, ≥2)
SYNC_STAGES, 3, flops on ps2_clk/ps2_data synchronisers (≥2)
TIMEOUT_CYC, 5000, clk cycles without a ps2_clk falling edge before a partial frame is discarded
NUM_DIGITS, 8, seven-segment digits driven (≥4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
seg  out  8*NUM_DIGITS  active-low segments; digit i at [8i+7:8i]; bit7 = dp
scan_code  out  8  currently held make code; 0x00 when none
key_down  out  1  a key is held
press_cnt  out  8  count of distinct key presses, mod 256
frame_err  out  8  count of rejected frames, saturates at 0xFF
overflow  out  1  sticky: a valid byte was dropped on a full FIFO

Behaviour:
- Reset (rst=1 sampled at posedge clk): all outputs 0 except seg = all 8'hFF; FIFO empty; bit counter 0; decoder IDLE; synchronisers reloaded with 1. Reset mid-frame discards the partial frame.
- Both inputs pass through SYNC_STAGES flops. A falling edge is synchronised-last-stage 1 -> 0 on ps2_clk. ps2_data is sampled on the same cycle.
- Frame: 11 bits, LSB-first shift. Order: start(0), d0..d7, odd parity, stop(1). Bit counter runs 0..10 and returns to 0 after bit 10.
- Frame check at bit 10: valid iff start=0, stop=1 and XOR(d,parity)=1. Valid -> push data. Invalid -> frame_err+1, saturating.
- Timeout: bit counter ≠0 with no falling edge for TIMEOUT_CYC cycles -> counter to 0, frame_err+1. An idle line never times out.
- FIFO: push when valid and not full. Push on full is accepted only if a pop occurs the same cycle. Otherwise the byte is dropped and overflow is set; only rst clears overflow. Push and pop together when non-empty keep the count unchanged.
- Decoder pops one byte per cycle when the FIFO is non-empty. States:
  - IDLE:
    - 0xE0 -> IDLE (prefix ignored, byte consumed).
    - 0xF0 -> BREAK.
    - Other code c with key_down=0 or c≠scan_code -> scan_code=c, key_down=1, press_cnt+1 (wraps 0xFF->0x00).
    - c equal to the held code (typematic repeat) -> no change.
  - BREAK:
    - 0xE0 -> stay in BREAK.
    - Code c with c=scan_code -> key_down=0, scan_code=0x00.
    - Code c that does not match -> no output change.
    - Any code c returns to IDLE.
- Latency: stop-bit edge detected at cycle N -> FIFO write N+1 -> pop/decode N+2 -> registered outputs change N+3.
- seg, updated combinationally from registers:
  - Digits 1:0: hex of scan_code while key_down, else 8'hFF (blank).
  - Digits 3:2: hex of press_cnt, always shown.
  - Digits ≥4: 8'hFF.
  - Hex patterns are active-low with dp off, e.g. 0 = 8'hC0 and 1 = 8'hF9.

Decomposition:
- Shared package:
  - PS/2 constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
  - Decoder state enum {IDLE, BREAK}.
  - 16-entry hex-to-seg constant table.
  - SEG_BLANK=8'hFF.
- Sub-module ps2_frame_rx holds the synchronisers, edge detect, shift register, parity/stop check, timeout and error counter. Its outputs are byte/valid/err pulses.
- FIFO, decoder and seg mapping stay in the top module.

Test Plan:
- Reset, then idle 20000 cycles -> seg all 8'hFF except digits 3:2 = 8'hC0,8'hC0; frame_err=0, key_down=0.
- Send 0x1C, then F0 1C -> after first frame N+3: scan_code=0x1C, key_down=1, press_cnt=1, seg[15:0]=hex"1C"; after break: key_down=0, digits 1:0 blank, press_cnt=1.
- Send 0x1C three times (typematic), then 0x32 -> press_cnt=2, scan_code=0x32.
- Frame with bad parity (0x1C, parity 0), then a frame with stop=0 -> frame_err=2, no FIFO push, press_cnt unchanged.
- Abort after 5 bits, wait TIMEOUT_CYC+10, then send a valid 0x2A -> frame_err=1, scan_code=0x2A.
- Stall decoder pops via force, send FIFO_DEPTH+1 frames -> overflow=1 and first FIFO_DEPTH bytes preserved; assert rst mid-frame -> all outputs at reset values next cycle.
